// File: rtl/i2c_uvc_pkg.sv
// Shared types for the I2C register-access sequencer: master command codes,
// response error codes, sequencer states and handshake phases.
package i2c_uvc_pkg;

  typedef enum logic [2:0] {
    CMD_START   = 3'b000,
    CMD_WR      = 3'b001,
    CMD_RD      = 3'b010,
    CMD_STOP    = 3'b011,
    CMD_RESTART = 3'b100
  } cmd_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_NACK    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_WR_DEV, ST_WR_REG, ST_WR_DATA,
    ST_RESTART, ST_WR_DEVR, ST_RD, ST_STOP, ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    PH_RDY, PH_BLANK, PH_WAIT
  } phase_e;

  // din for the single read byte: master NACKs it since it is the last one
  localparam logic [7:0] RD_LAST_NACK = 8'h01;

  function automatic logic is_byte_cmd(input cmd_e c);
    return (c == CMD_WR) || (c == CMD_RD);
  endfunction

endpackage

// File: rtl/i2c_cmd_issuer.sv
// Single-command handshake with the byte-level I2C master: wait ready, strobe,
// blank one cycle, then wait for done_tick (WR/RD) or ready (START/RESTART/STOP).
module i2c_cmd_issuer
  import i2c_uvc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       go,
  input  logic [2:0] cmd,
  input  logic [7:0] din,
  input  logic       ready_i,
  input  logic       done_tick_i,
  input  logic       ack_i,
  input  logic [7:0] dout_i,
  output logic [2:0] cmd_o,
  output logic [7:0] din_o,
  output logic       wr_i2c_o,
  output logic       cmd_done,
  output logic       ack,
  output logic [7:0] data
);

  phase_e phase, phase_next;
  logic   byte_cmd;

  assign byte_cmd = is_byte_cmd(cmd_e'(cmd));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) phase <= PH_RDY;
    else       phase <= phase_next;
  end

  always_comb begin
    phase_next = phase;
    wr_i2c_o   = 1'b0;
    cmd_done   = 1'b0;
    if (!go) begin
      phase_next = PH_RDY;
    end else begin
      case (phase)
        PH_RDY: if (ready_i) begin
          wr_i2c_o   = 1'b1;
          phase_next = PH_BLANK;
        end
        // master's ready is stale in the cycle right after the strobe
        PH_BLANK: phase_next = PH_WAIT;
        PH_WAIT: if (byte_cmd ? done_tick_i : ready_i) begin
          cmd_done   = 1'b1;
          phase_next = PH_RDY;
        end
        default: phase_next = PH_RDY;
      endcase
    end
  end

  assign cmd_o = go ? cmd : 3'b000;
  assign din_o = go ? din : 8'h00;
  assign ack   = ack_i;
  assign data  = dout_i;

endmodule

// File: rtl/i2c_reg_xfer_ctrl.sv
// Register read/write sequencer in front of the byte-level I2C master.
// Optional per-wait watchdog enabled by I2C_XFER_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | ready for a request
// START      | issue START
// WR_DEV     | write {dev,0}
// WR_REG     | write register address
// WR_DATA    | write data byte (write only)
// RESTART    | repeated start (read only)
// WR_DEVR    | write {dev,1} (read only)
// RD         | read one byte, master NACKs it
// STOP       | issue STOP
// RESP       | hold response until consumed
module i2c_reg_xfer_ctrl
  import i2c_uvc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rnw_i,
  input  logic [6:0] req_dev_addr_i,
  input  logic [7:0] req_reg_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_rdata_o,
  output logic [1:0] rsp_err_o,
  output logic [2:0] cmd_o,
  output logic [7:0] din_o,
  output logic       wr_i2c_o,
  input  logic       ready_i,
  input  logic       done_tick_i,
  input  logic       ack_i,
  input  logic [7:0] dout_i
);

  state_e     state, state_next;
  logic       rnw;
  logic [6:0] dev;
  logic [7:0] reg_addr, wdata, rdata;
  err_e       err;
  cmd_e       cmd;
  logic [7:0] din, data;
  logic       go, cmd_done, ack, timeout;

  assign go = (state != ST_IDLE) && (state != ST_RESP);

  i2c_cmd_issuer u_issuer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .go          (go),
    .cmd         (cmd),
    .din         (din),
    .ready_i     (ready_i),
    .done_tick_i (done_tick_i),
    .ack_i       (ack_i),
    .dout_i      (dout_i),
    .cmd_o       (cmd_o),
    .din_o       (din_o),
    .wr_i2c_o    (wr_i2c_o),
    .cmd_done    (cmd_done),
    .ack         (ack),
    .data        (data)
  );

`ifdef I2C_XFER_TIMEOUT_EN
  logic [31:0] wait_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                    wait_cnt <= '0;
    else if (state_next != state) wait_cnt <= '0;
    else if (go)                  wait_cnt <= wait_cnt + 32'd1;
  end

  assign timeout = go && (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req_valid_i) state_next = ST_START;
      ST_RESP: if (rsp_ready_i) state_next = ST_IDLE;
      default: begin
        if (cmd_done) begin
          case (state)
            ST_START:   state_next = ST_WR_DEV;
            ST_WR_DEV:  state_next = ack ? ST_STOP : ST_WR_REG;
            ST_WR_REG:  state_next = ack ? ST_STOP : (rnw ? ST_RESTART : ST_WR_DATA);
            ST_WR_DATA: state_next = ST_STOP;
            ST_RESTART: state_next = ST_WR_DEVR;
            ST_WR_DEVR: state_next = ack ? ST_STOP : ST_RD;
            ST_RD:      state_next = ST_STOP;
            ST_STOP:    state_next = ST_RESP;
            default:    state_next = ST_IDLE;
          endcase
        end else if (timeout) begin
          // master assumed hung: no STOP
          state_next = ST_RESP;
        end
      end
    endcase
  end

  always_comb begin
    cmd = CMD_START;
    din = 8'h00;
    case (state)
      ST_START:   cmd = CMD_START;
      ST_WR_DEV:  begin cmd = CMD_WR; din = {dev, 1'b0}; end
      ST_WR_REG:  begin cmd = CMD_WR; din = reg_addr; end
      ST_WR_DATA: begin cmd = CMD_WR; din = wdata; end
      ST_RESTART: cmd = CMD_RESTART;
      ST_WR_DEVR: begin cmd = CMD_WR; din = {dev, 1'b1}; end
      ST_RD:      begin cmd = CMD_RD; din = RD_LAST_NACK; end
      ST_STOP:    cmd = CMD_STOP;
      default:    ;
    endcase
  end

  assign req_ready_o = (state == ST_IDLE);
  assign rsp_valid_o = (state == ST_RESP);
  assign rsp_rdata_o = rdata;
  assign rsp_err_o   = err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rnw      <= 1'b0;
      dev      <= '0;
      reg_addr <= '0;
      wdata    <= '0;
      rdata    <= '0;
      err      <= ERR_OK;
    end else if (state == ST_IDLE && req_valid_i) begin
      rnw      <= req_rnw_i;
      dev      <= req_dev_addr_i;
      reg_addr <= req_reg_addr_i;
      wdata    <= req_wdata_i;
      rdata    <= '0;
      err      <= ERR_OK;
    end else if (cmd_done && cmd == CMD_WR && ack) begin
      err <= ERR_NACK;
    end else if (cmd_done && cmd == CMD_RD) begin
      rdata <= data;
    end else if (timeout && !cmd_done) begin
      err   <= ERR_TIMEOUT;
      rdata <= '0;
    end
  end

endmodule

// File: tb/tb_i2c_reg_xfer_ctrl.sv
// Bench for i2c_reg_xfer_ctrl: behavioural I2C master with random latencies,
// transaction-level expected command list and response. Honours I2C_XFER_TIMEOUT_EN.
module tb_i2c_reg_xfer_ctrl;

  logic       clk_i, rst_i;
  logic       req_valid_i, req_ready_o, req_rnw_i;
  logic [6:0] req_dev_addr_i;
  logic [7:0] req_reg_addr_i, req_wdata_i;
  logic       rsp_valid_o, rsp_ready_i;
  logic [7:0] rsp_rdata_o;
  logic [1:0] rsp_err_o;
  logic [2:0] cmd_o;
  logic [7:0] din_o;
  logic       wr_i2c_o, ready_i, done_tick_i, ack_i;
  logic [7:0] dout_i;

  i2c_reg_xfer_ctrl #(.TIMEOUT_CYCLES(100)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rnw_i(req_rnw_i),
    .req_dev_addr_i(req_dev_addr_i), .req_reg_addr_i(req_reg_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .cmd_o(cmd_o), .din_o(din_o), .wr_i2c_o(wr_i2c_o),
    .ready_i(ready_i), .done_tick_i(done_tick_i), .ack_i(ack_i), .dout_i(dout_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural I2C master ----------------
  logic [10:0] cmd_log[$];
  int          wr_hi = 0;
  int          wr_total = 0;
  int          cfg_wr_base = 0;
  int          cfg_nack = -1;
  logic [7:0]  cfg_dout = 8'h00;
  bit          stuck = 0;

  initial begin
    int         busy;
    logic       s_wr;
    logic [2:0] s_cmd, cur_cmd;
    logic [7:0] s_din;
    busy = 0; cur_cmd = 3'b000;
    ready_i = 1'b1; done_tick_i = 1'b0; ack_i = 1'b0; dout_i = 8'h00;
    forever begin
      @(negedge clk_i);
      s_wr = wr_i2c_o; s_cmd = cmd_o; s_din = din_o;
      if (wr_i2c_o) wr_hi++;
      @(posedge clk_i); #1;
      done_tick_i = 1'b0;
      ack_i  = 1'($urandom);
      dout_i = 8'($urandom);
      if (rst_i) begin
        busy = 0;
        ready_i = 1'b1;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          if (cur_cmd == 3'b001) begin
            ack_i = ((wr_total - cfg_wr_base) == cfg_nack);
            wr_total++;
            done_tick_i = 1'b1;
          end else if (cur_cmd == 3'b010) begin
            ack_i = 1'b1;
            dout_i = cfg_dout;
            done_tick_i = 1'b1;
          end
          ready_i = 1'b1;
        end
      end else if (s_wr) begin
        cmd_log.push_back({s_cmd, s_din});
        cur_cmd = s_cmd;
        ready_i = 1'b0;
        busy = $urandom_range(4, 1);
      end else if ($urandom_range(7, 0) == 0) begin
        done_tick_i = 1'b1;  // stray tick while nothing is pending
      end
      if (stuck) ready_i = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue_req(input logic rnw, input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd);
    @(posedge clk_i); #1;
    req_rnw_i = rnw; req_dev_addr_i = dev; req_reg_addr_i = ra; req_wdata_i = wd;
    req_valid_i = 1'b1;
    @(negedge clk_i);
    check("req_ready_idle", req_ready_o, 1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    req_rnw_i = 1'($urandom); req_dev_addr_i = 7'($urandom);
    req_reg_addr_i = 8'($urandom); req_wdata_i = 8'($urandom);
  endtask

  task automatic finish_rsp(input int hold, input logic [7:0] exp_rd, input logic [1:0] exp_err);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("hold_valid", rsp_valid_o, 1);
      check("hold_rdata", rsp_rdata_o, exp_rd);
      check("hold_err", rsp_err_o, exp_err);
      check("hold_req_ready", req_ready_o, 0);
    end
    @(posedge clk_i); #1; rsp_ready_i = 1'b1;
    @(negedge clk_i);
    check("hs_valid", rsp_valid_o, 1);
    @(posedge clk_i); #1; rsp_ready_i = 1'b0;
    @(negedge clk_i);
    check("post_hs_req_ready", req_ready_o, 1);
    check("post_hs_valid", rsp_valid_o, 0);
  endtask

  // Expected strobes come from the request-level rules: fixed op list per
  // direction, truncated after the first NACKed write, always closed by STOP.
  task automatic run_xfer(input logic rnw, input logic [6:0] dev, input logic [7:0] ra,
                          input logic [7:0] wd, input int nack, input logic [7:0] dout, input int hold);
    logic [10:0] ops[$];
    logic [10:0] exp_q[$];
    logic [1:0]  exp_err;
    logic [7:0]  exp_rd;
    int          wi, base, hi0, cyc, n;
    bit          cut;
    exp_err = 2'b00; exp_rd = 8'h00; wi = 0; cut = 0;
    ops.push_back({3'b001, dev, 1'b0});
    ops.push_back({3'b001, ra});
    if (rnw) begin
      ops.push_back({3'b100, 8'h00});
      ops.push_back({3'b001, dev, 1'b1});
      ops.push_back({3'b010, 8'h01});
    end else begin
      ops.push_back({3'b001, wd});
    end
    exp_q.push_back({3'b000, 8'h00});
    foreach (ops[i]) begin
      if (!cut) begin
        exp_q.push_back(ops[i]);
        if (ops[i][10:8] == 3'b001) begin
          if (wi == nack) begin cut = 1; exp_err = 2'b01; end
          wi++;
        end else if (ops[i][10:8] == 3'b010) begin
          exp_rd = dout;
        end
      end
    end
    exp_q.push_back({3'b011, 8'h00});

    base = cmd_log.size(); hi0 = wr_hi;
    cfg_wr_base = wr_total; cfg_nack = nack; cfg_dout = dout;
    issue_req(rnw, dev, ra, wd);
    cyc = 0;
    do begin
      @(negedge clk_i);
      cyc++;
      req_valid_i = 1'($urandom);  // must be ignored while busy
    end while (!rsp_valid_o && cyc < 2000);
    req_valid_i = 1'b0;
    check("rsp_seen", rsp_valid_o, 1);
    check("busy_req_ready", req_ready_o, 0);
    check("rsp_err", rsp_err_o, exp_err);
    check("rsp_rdata", rsp_rdata_o, exp_rd);
    n = cmd_log.size() - base;
    check("n_strobes", n, exp_q.size());
    check("strobe_cycles", wr_hi - hi0, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      check("strobe_cmd", cmd_log[base+i][10:8], exp_q[i][10:8]);
      if (exp_q[i][10:8] == 3'b001 || exp_q[i][10:8] == 3'b010)
        check("strobe_din", cmd_log[base+i][7:0], exp_q[i][7:0]);
    end
    finish_rsp(hold, exp_rd, exp_err);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base, cyc;
    rst_i = 1'b1; req_valid_i = 1'b0; req_rnw_i = 1'b0; req_dev_addr_i = '0;
    req_reg_addr_i = '0; req_wdata_i = '0; rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_req_ready", req_ready_o, 1);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rdata", rsp_rdata_o, 0);
    check("rst_err", rsp_err_o, 0);
    check("rst_cmd", cmd_o, 0);
    check("rst_din", din_o, 0);
    check("rst_wr", wr_i2c_o, 0);
    @(posedge clk_i); #1; rst_i = 1'b0;
    repeat (2) @(posedge clk_i);

    run_xfer(1'b0, 7'h50, 8'h10, 8'hA5, -1, 8'h00, 0);
    run_xfer(1'b1, 7'h50, 8'h10, 8'h00, -1, 8'h3C, 0);
    run_xfer(1'b0, 7'h50, 8'h10, 8'hA5, 0, 8'h00, 0);
    run_xfer(1'b1, 7'h22, 8'h7F, 8'h00, 2, 8'h99, 5);
    run_xfer(1'b0, 7'h13, 8'hFE, 8'h5A, 2, 8'h00, 5);

    // reset while waiting on the register-address byte
    base = cmd_log.size(); cfg_wr_base = wr_total; cfg_nack = -1;
    issue_req(1'b0, 7'h50, 8'h10, 8'hA5);
    cyc = 0;
    do begin @(negedge clk_i); cyc++; end while (cmd_log.size() < base + 3 && cyc < 500);
    check("mid_rst_reach", cmd_log.size() - base, 3);
    @(posedge clk_i); #1; rst_i = 1'b1; #1;
    check("mid_rst_wr", wr_i2c_o, 0);
    check("mid_rst_req_ready", req_ready_o, 1);
    check("mid_rst_rsp_valid", rsp_valid_o, 0);
    repeat (3) @(posedge clk_i);
    #1; rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    run_xfer(1'b0, 7'h50, 8'h10, 8'hA5, -1, 8'h00, 1);

    for (int t = 0; t < 16; t++) begin
      int nk;
      nk = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 0)) : -1;
      run_xfer(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), nk, 8'($urandom),
               $urandom_range(5, 0));
    end

    // master hung: ready never returns
    stuck = 1;
    repeat (3) @(posedge clk_i);
    base = cmd_log.size();
    issue_req(1'b0, 7'h50, 8'h10, 8'hA5);
`ifdef I2C_XFER_TIMEOUT_EN
    cyc = 0;
    do begin @(negedge clk_i); cyc++; end while (!rsp_valid_o && cyc < 1000);
    check("to_rsp_seen", rsp_valid_o, 1);
    check("to_cycles", cyc, 101);
    check("to_err", rsp_err_o, 2'b10);
    check("to_rdata", rsp_rdata_o, 0);
    check("to_no_strobe", cmd_log.size() - base, 0);
    finish_rsp(2, 8'h00, 2'b10);
    stuck = 0;
    repeat (3) @(posedge clk_i);
`else
    cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) cyc++;
    end
    check("no_to_rsp", cyc, 0);
    check("no_to_busy", req_ready_o, 0);
    stuck = 0;
    @(posedge clk_i); #1; rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1; rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
`endif
    run_xfer(1'b1, 7'h50, 8'h10, 8'h00, -1, 8'hC3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
